// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared widths, instruction modes, ALU opcodes and sequencer FSM states
package alu_seq_pkg;
    localparam int DEF_W     = 6;
    localparam int DEF_OPW   = 4;
    localparam int DEF_DEPTH = 4;
    typedef enum logic [1:0] {
        MODE_ALU  = 2'b00,
        MODE_LOAD = 2'b01,
        MODE_CMP  = 2'b10,
        MODE_HALT = 2'b11
    } mode_e;
    localparam logic [DEF_OPW-1:0] OP_NOT  = 4'b0000;
    localparam logic [DEF_OPW-1:0] OP_ILL  = 4'b0001;
    localparam logic [DEF_OPW-1:0] OP_AND  = 4'b0010;
    localparam logic [DEF_OPW-1:0] OP_SUB  = 4'b0011;
    localparam logic [DEF_OPW-1:0] OP_DEC  = 4'b0100;
    localparam logic [DEF_OPW-1:0] OP_EQ   = 4'b0101;
    localparam logic [DEF_OPW-1:0] OP_LESS = 4'b0110;
    localparam logic [DEF_OPW-1:0] OP_INC  = 4'b1000;
    localparam logic [DEF_OPW-1:0] OP_ADD  = 4'b1010;
    localparam logic [DEF_OPW-1:0] OP_XOR  = 4'b1101;
    localparam logic [DEF_OPW-1:0] OP_OR   = 4'b1111;
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_HALT = 2'b10
    } state_e;
endpackage

// File: rtl/alu_op_sequencer_fifo.sv
// seq_fifo: synchronous FIFO with full/empty/count; pointers wrap modulo DEPTH
//  Ports: clk, rst_n (async active-low), push/din write, pop/dout read head,
//         full, empty, count (0..DEPTH)
module seq_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp, rp;
    logic             do_push, do_pop;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rp];
    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= wp + AW'(1);
            if (do_pop) rp <= rp + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: buffers {mode,op,imm} words and issues them to an external ALU around an accumulator
//  Ports: in_valid/in_ready/in_mode/in_op/in_imm instruction push; resume leaves HALT;
//         alu_x/alu_y/alu_op drive the ALU, alu_z/alu_iof/alu_baf/alu_zf come back;
//         acc, flags {IOF,BAF,ZF}, cond, retire pulse, busy, halted, err (sticky).
//  Macro ILLEGAL_OP_TRAP_EN: ALU/CMP with op 0001 traps (err=1, HALT) instead of issuing.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int W          = DEF_W,
    parameter int OPW        = DEF_OPW,
    parameter int FIFO_DEPTH = DEF_DEPTH
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [1:0]     in_mode,
    input  logic [OPW-1:0] in_op,
    input  logic [W-1:0]   in_imm,
    input  logic           resume,
    output logic [W-1:0]   alu_x,
    output logic [W-1:0]   alu_y,
    output logic [OPW-1:0] alu_op,
    input  logic [W-1:0]   alu_z,
    input  logic           alu_iof,
    input  logic           alu_baf,
    input  logic           alu_zf,
    output logic [W-1:0]   acc,
    output logic [2:0]     flags,
    output logic           cond,
    output logic           retire,
    output logic           busy,
    output logic           halted,
    output logic           err
);
    localparam int FW = 2 + OPW + W;
    logic [FW-1:0]                 head;
    logic                          full, empty;
    logic [$clog2(FIFO_DEPTH):0]   count;
    state_e                        state, state_n;
    mode_e                         mode_h, ex_mode;
    logic [OPW-1:0]                op_h;
    logic [W-1:0]                  imm_h;
    logic                          pop, illegal, issue;
    assign mode_h = mode_e'(head[FW-1 -: 2]);
    assign op_h   = head[W +: OPW];
    assign imm_h  = head[W-1:0];
    assign pop    = state == ST_IDLE && !empty;
`ifdef ILLEGAL_OP_TRAP_EN
    assign illegal = pop && (mode_h == MODE_ALU || mode_h == MODE_CMP) && op_h == OPW'(OP_ILL);
`else
    assign illegal = 1'b0;
`endif
    assign issue = pop && (mode_h == MODE_ALU || mode_h == MODE_CMP) && !illegal;
    seq_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (in_valid),
        .pop   (pop),
        .din   ({in_mode, in_op, in_imm}),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_n;
    end
    always_comb begin
        state_n = state == ST_EXEC ? ST_IDLE :
                  state == ST_HALT ? (resume ? ST_IDLE : ST_HALT) :
                  !pop ? ST_IDLE :
                  (mode_h == MODE_HALT || illegal) ? ST_HALT :
                  issue ? ST_EXEC : ST_IDLE;
    end
    always_comb begin
        in_ready = !full;
        busy     = state != ST_IDLE || count != '0;
        halted   = state == ST_HALT;
    end
    // acc is sampled into alu_x on the pop edge, after any prior EXEC write, so chains see fresh results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_x   <= '0;
            alu_y   <= '0;
            alu_op  <= '0;
            acc     <= '0;
            flags   <= '0;
            cond    <= 1'b0;
            retire  <= 1'b0;
            err     <= 1'b0;
            ex_mode <= MODE_ALU;
        end else begin
            retire <= (pop && (mode_h == MODE_LOAD || mode_h == MODE_HALT || illegal)) || state == ST_EXEC;
            err    <= err | illegal;
            if (pop && mode_h == MODE_LOAD) acc <= imm_h;
            if (issue) begin
                alu_x   <= acc;
                alu_y   <= imm_h;
                alu_op  <= op_h;
                ex_mode <= mode_h;
            end
            if (state == ST_EXEC && ex_mode == MODE_ALU) begin
                acc   <= alu_z;
                flags <= {alu_iof, alu_baf, alu_zf};
            end
            if (state == ST_EXEC && ex_mode == MODE_CMP) cond <= alu_z[0];
        end
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed + random stimulus against an instruction-level reference model
module tb_alu_op_sequencer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid = 1'b0, resume = 1'b0;
    logic [1:0] in_mode = 2'd0;
    logic [3:0] in_op = 4'd0;
    logic [5:0] in_imm = 6'd0;
    logic       in_ready, retire, busy, halted, err, cond;
    logic [5:0] alu_x, alu_y, alu_z, acc;
    logic [3:0] alu_op;
    logic       alu_iof, alu_baf, alu_zf;
    logic [2:0] flags;
    int n_cmp = 0, n_err = 0, rcount = 0;
    logic [5:0] rlog [$];
`ifdef ILLEGAL_OP_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    alu_op_sequencer dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .in_op(in_op), .in_imm(in_imm), .resume(resume),
        .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op), .alu_z(alu_z),
        .alu_iof(alu_iof), .alu_baf(alu_baf), .alu_zf(alu_zf),
        .acc(acc), .flags(flags), .cond(cond), .retire(retire),
        .busy(busy), .halted(halted), .err(err)
    );
    always #5 clk = ~clk;
    // stand-in ALU: returns {iof, baf, zf, z}
    function automatic logic [8:0] alu_f(input logic [5:0] x, input logic [5:0] y, input logic [3:0] op);
        logic [6:0] r;
        case (op)
            4'b0000: r = {1'b0, ~x};
            4'b0010: r = {1'b0, x & y};
            4'b0011: r = {1'b0, x} - {1'b0, y};
            4'b0100: r = {1'b0, x} - 7'd1;
            4'b0101: r = {6'd0, x == y};
            4'b0110: r = {6'd0, x < y};
            4'b1000: r = {1'b0, x} + 7'd1;
            4'b1010: r = {1'b0, x} + {1'b0, y};
            4'b1101: r = {1'b0, x ^ y};
            4'b1111: r = {1'b0, x | y};
            default: r = 7'd0;
        endcase
        return {r[6], r[5], r[5:0] == 6'd0, r[5:0]};
    endfunction
    assign {alu_iof, alu_baf, alu_zf, alu_z} = alu_f(alu_x, alu_y, alu_op);
    typedef struct packed {logic [1:0] mode; logic [3:0] op; logic [5:0] imm;} ins_t;
    ins_t q [$];
    ins_t e;
    int         m_st = 0;
    logic [5:0] m_acc = 0, m_x = 0, m_y = 0;
    logic [3:0] m_op = 0;
    logic [1:0] m_mode = 0;
    logic [2:0] m_flags = 0;
    logic       m_cond = 0, m_retire = 0, m_err = 0, m_push = 0;
    logic [8:0] r;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_st = 0; m_acc = 0; m_x = 0; m_y = 0; m_op = 0; m_mode = 0;
            m_flags = 0; m_cond = 0; m_retire = 0; m_err = 0;
        end else begin
            m_push = in_valid && q.size() < 4;
            m_retire = 0;
            if (m_st == 1) begin
                r = alu_f(m_x, m_y, m_op);
                if (m_mode == 2'b00) begin
                    m_acc = r[5:0];
                    m_flags = r[8:6];
                end else m_cond = r[0];
                m_retire = 1;
                m_st = 0;
            end else if (m_st == 2) begin
                if (resume) m_st = 0;
            end else if (q.size() > 0) begin
                e = q.pop_front();
                if (e.mode == 2'b01) begin
                    m_acc = e.imm; m_retire = 1;
                end else if (e.mode == 2'b11) begin
                    m_retire = 1; m_st = 2;
                end else if (TRAP && e.op == 4'b0001) begin
                    m_err = 1; m_retire = 1; m_st = 2;
                end else begin
                    m_x = m_acc; m_y = e.imm; m_op = e.op; m_mode = e.mode; m_st = 1;
                end
            end
            if (m_push) q.push_back({in_mode, in_op, in_imm});
        end
    end
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, act, exp, $time);
        end
    endtask
    always @(negedge clk) begin
        chk("in_ready", in_ready, q.size() < 4);
        chk("busy", busy, m_st != 0 || q.size() != 0);
        chk("halted", halted, m_st == 2);
        chk("retire", retire, m_retire);
        chk("acc", acc, m_acc);
        chk("flags", flags, m_flags);
        chk("cond", cond, m_cond);
        chk("err", err, m_err);
        chk("alu_x", alu_x, m_x);
        chk("alu_y", alu_y, m_y);
        chk("alu_op", alu_op, m_op);
        if (retire) begin
            rcount++;
            rlog.push_back(acc);
        end
    end
    task automatic push(input logic [1:0] m, input logic [3:0] o, input logic [5:0] i);
        bit ok = 0;
        in_valid = 1; in_mode = m; in_op = o; in_imm = i;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 0;
        chk("push_accepted", ok, 1);
    endtask
    task automatic wait_idle();
        int k = 0;
        resume = 1;
        while (k < 200) begin
            @(negedge clk);
            if (!busy) break;
            k++;
        end
        chk("drain", busy, 0);
        @(posedge clk); #1;
        resume = 0;
    endtask
    logic [3:0] ops [11] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101,
                             4'b0110, 4'b1000, 4'b1010, 4'b1101, 4'b1111};
    int r0, sel;
    initial begin
        rst_n = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_acc", acc, 0);
        chk("rst_retire", retire, 0);
        @(posedge clk); #1;
        rst_n = 1;
        @(negedge clk);
        chk("rel_in_ready", in_ready, 1);
        chk("rel_busy", busy, 0);
        @(posedge clk); #1;
        // chain: 10 -> NOT 53 -> INC 54 -> XOR 110010 = 000100
        r0 = rcount;
        push(2'b01, 4'b0000, 6'b001010);
        push(2'b00, 4'b0000, 6'b000000);
        push(2'b00, 4'b1000, 6'b000000);
        push(2'b00, 4'b1101, 6'b110010);
        wait_idle();
        chk("chain_acc", acc, 6'b000100);
        chk("chain_model_acc", m_acc, 6'b000100);
        chk("chain_retires", rcount - r0, 4);
        chk("chain_flags", flags, 3'b000);
        // compares
        push(2'b01, 4'b0000, 6'b001100);
        push(2'b10, 4'b0110, 6'b010000);
        wait_idle();
        chk("cmp_less_cond", cond, 1);
        chk("cmp_acc", acc, 6'b001100);
        push(2'b10, 4'b0101, 6'b010000);
        wait_idle();
        chk("cmp_eq_cond", cond, 0);
        chk("cmp_eq_acc", acc, 6'b001100);
        // backpressure while halted
        push(2'b11, 4'b0000, 6'd0);
        for (int k = 0; k < 20 && !halted; k++) @(negedge clk);
        chk("halt_entered", halted, 1);
        @(posedge clk); #1;
        rlog.delete();
        for (int i = 11; i <= 14; i++) push(2'b01, 4'b0000, 6'(i));
        @(negedge clk);
        chk("full_not_ready", in_ready, 0);
        chk("full_halted", halted, 1);
        @(posedge clk); #1;
        resume = 1;
        push(2'b01, 4'b0000, 6'd15);
        resume = 0;
        wait_idle();
        chk("drain_count", rlog.size(), 5);
        for (int i = 0; i < 5 && i < rlog.size(); i++) chk("drain_order", rlog[i], 11 + i);
        chk("drain_ready", in_ready, 1);
        // continuous stream of LOADs
        rlog.delete();
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1; in_mode = 2'b01; in_op = 0; in_imm = 6'(i);
            @(negedge clk);
            chk("stream_ready", in_ready, 1);
            @(posedge clk); #1;
        end
        in_valid = 0;
        wait_idle();
        chk("stream_count", rlog.size(), 8);
        for (int i = 0; i < 8 && i < rlog.size(); i++) chk("stream_order", rlog[i], i + 1);
        // reset during EXEC of ADD
        push(2'b01, 4'b0000, 6'd5);
        push(2'b00, 4'b1010, 6'd3);
        @(posedge clk);
        #3;
        chk("pre_rst_exec", alu_op, 4'b1010);
        rst_n = 0;
        @(negedge clk);
        chk("midrst_acc", acc, 0);
        chk("midrst_retire", retire, 0);
        @(posedge clk); #1;
        rst_n = 1;
        @(negedge clk);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_acc_after", acc, 0);
        @(posedge clk); #1;
        // op 0001
        push(2'b01, 4'b0000, 6'd7);
        push(2'b00, 4'b0001, 6'd3);
        repeat (3) @(negedge clk);
        if (TRAP) begin
            chk("trap_err", err, 1);
            chk("trap_halted", halted, 1);
            chk("trap_acc", acc, 6'd7);
        end else begin
            chk("op1_acc", acc, 6'd0);
            chk("op1_err", err, 0);
        end
        @(posedge clk); #1;
        wait_idle();
        // random traffic
        for (int i = 0; i < 2000; i++) begin
            in_valid = $urandom_range(0, 3) != 0;
            sel = $urandom_range(0, 15);
            in_mode = sel == 0 ? 2'b11 : sel < 6 ? 2'b01 : sel < 11 ? 2'b00 : 2'b10;
            in_op = ops[$urandom_range(0, 10)];
            in_imm = 6'($urandom);
            resume = $urandom_range(0, 3) == 0;
            @(posedge clk); #1;
        end
        in_valid = 0;
        wait_idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
